// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST front end and gate networks.
// feat_vec_t is the 49-bit in_bits word the classifiers consume.
package mnist_pkg;

  localparam int MNIST_PIX_W  = 8;
  localparam int MNIST_IMG_W  = 28;
  localparam int MNIST_POOL   = 4;
  localparam int MNIST_GRID   = MNIST_IMG_W / MNIST_POOL;
  localparam int MNIST_N_FEAT = MNIST_GRID * MNIST_GRID;
  localparam int MNIST_ACC_W  = MNIST_PIX_W + 2 * $clog2(MNIST_POOL);

  typedef logic [MNIST_N_FEAT-1:0] feat_vec_t;
  typedef logic [MNIST_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/mnist_block_acc.sv
// Bank of per-column-slot block accumulators with load/add and a
// threshold compare on the running sum plus the current pixel.
import mnist_pkg::*;

module mnist_block_acc #(
  parameter int PIX_W  = MNIST_PIX_W,
  parameter int GRID   = MNIST_GRID,
  parameter int ACC_W  = MNIST_ACC_W,
  parameter int THRESH = 1024,
  parameter int SW     = $clog2(GRID)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [SW-1:0]    slot,
  input  logic [PIX_W-1:0] pix,
  output logic             hit
);

  logic [ACC_W-1:0] acc [GRID];
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;

  assign ext = ACC_W'(pix);
  assign sum = acc[slot] + ext;
  assign hit = sum >= ACC_W'(THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else if (en) begin
      acc[slot] <= load ? ext : sum;
    end
  end

endmodule

// File: rtl/mnist_pool_binarizer.sv
// Raster 28x28 pixel stream -> 4x4 block sums -> thresholded 49-bit
// feature vector with valid/ready output and framing-error pulse.
import mnist_pkg::*;

module mnist_pool_binarizer #(
  parameter int PIX_W        = MNIST_PIX_W,
  parameter int IMG_W        = MNIST_IMG_W,
  parameter int POOL         = MNIST_POOL,
  parameter int BLOCK_THRESH = 1024,
  localparam int GRID        = IMG_W / POOL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GRID*GRID-1:0] out_bits,
  output logic                 frame_err
);

  localparam int NF    = GRID * GRID;
  localparam int ACC_W = PIX_W + 2 * $clog2(POOL);
  localparam int RW    = $clog2(IMG_W);
  localparam int SW    = $clog2(GRID);
  localparam int IW    = $clog2(NF);
  localparam logic [RW-1:0] LAST = RW'(IMG_W - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t        state;
  logic [RW-1:0] row, col, r, c;
  logic          accept, start, proc;
  logic          first, last, fin, hit;
  logic [SW-1:0] slot;
  logic [IW-1:0] bidx;
  logic [NF-1:0] work, work_nx;

  // Only the frame-closing pixel can stall, and only when it would
  // overwrite a vector the sink has not taken yet.
  assign pix_ready = !(state == S_ACCUM && row == LAST &&
                       col == LAST && out_valid && !out_ready);

  assign accept = pix_valid && pix_ready;
  assign start  = accept && pix_sof;
  assign proc   = accept && (pix_sof || state == S_ACCUM);

  assign r = start ? '0 : row;
  assign c = start ? '0 : col;

  assign first = (32'(r) % POOL == 0) && (32'(c) % POOL == 0);
  assign last  = (32'(r) % POOL == POOL - 1) &&
                 (32'(c) % POOL == POOL - 1);
  assign fin   = (r == LAST) && (c == LAST);
  assign slot  = SW'(32'(c) / POOL);
  assign bidx  = IW'((32'(r) / POOL) * GRID + 32'(c) / POOL);

  mnist_block_acc #(
    .PIX_W (PIX_W),
    .GRID  (GRID),
    .ACC_W (ACC_W),
    .THRESH(BLOCK_THRESH),
    .SW    (SW)
  ) u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (proc),
    .load (first),
    .slot (slot),
    .pix  (pix_data),
    .hit  (hit)
  );

  always_comb begin
    work_nx = start ? '0 : work;
    if (proc && last) work_nx[bidx] = hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= start && state == S_ACCUM;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (proc) begin
        work <= work_nx;
        if (fin) begin
          out_bits  <= work_nx;
          out_valid <= 1'b1;
          state     <= S_IDLE;
          row       <= '0;
          col       <= '0;
        end else begin
          state <= S_ACCUM;
          if (c == LAST) begin
            col <= '0;
            row <= r + 1'b1;
          end else begin
            col <= c + 1'b1;
            row <= r;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mnist_pool_binarizer.sv
// Self-checking bench for mnist_pool_binarizer against a block-sum
// reference model computed directly from a 28x28 image array.
module tb_mnist_pool_binarizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [48:0] out_bits;
  logic        frame_err;

  int          checks = 0;
  int          fails = 0;
  int          err_cnt = 0;
  int          img [784];
  logic [48:0] got_q [$];

  always #5 clk = ~clk;

  mnist_pool_binarizer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .pix_sof  (pix_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits (out_bits),
    .frame_err(frame_err)
  );

  // Sample just before each rising edge.
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) got_q.push_back(out_bits);
    if (rst_n && frame_err) err_cnt++;
  end

  function automatic logic [48:0] model();
    logic [48:0] v;
    v = '0;
    for (int br = 0; br < 7; br++)
      for (int bc = 0; bc < 7; bc++) begin
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            s += img[(br * 4 + i) * 28 + bc * 4 + j];
        v[br * 7 + bc] = (s >= 1024);
      end
    return v;
  endfunction

  function automatic logic [48:0] first_got();
    logic [48:0] g;
    g = 'x;
    if (got_q.size() > 0) g = got_q[0];
    return g;
  endfunction

  task automatic send(input int d, input bit s);
    int t;
    t = 0;
    pix_valid = 1'b1;
    pix_data  = d[7:0];
    pix_sof   = s;
    #1;
    while (!pix_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!pix_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout pix_ready=%0b required 1", pix_ready);
    end
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send(img[i], i == 0);
      if (gaps && $urandom_range(3, 0) == 0) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(hi, lo));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%b required 0", out_valid);
    end
    checks++;
    if (out_bits !== 49'h0) begin
      fails++;
      $display("FAIL reset_bits got=%h required 0", out_bits);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err got=%b required 0", frame_err);
    end
    rst_n = 1'b1;
    idle(1);
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%b required 1", pix_ready);
    end
    idle(1);
  endtask

  task automatic test_patterns();
    logic [48:0] req [4];
    for (int k = 0; k < 4; k++) begin
      fill(0, 0);
      case (k)
        1: fill(255, 255);
        2: for (int i = 0; i < 4; i++)
             for (int j = 0; j < 4; j++)
               img[(8 + i) * 28 + 12 + j] = 255;
        3: for (int i = 0; i < 4; i++)
             for (int j = 0; j < 4; j++) begin
               img[i * 28 + j]     = 64;
               img[i * 28 + 4 + j] = 63;
               img[i * 28 + 8 + j] = (i == 3 && j == 3) ? 63 : 64;
             end
        default: ;
      endcase
      req[0] = 49'h0;
      req[1] = 49'h1_FFFF_FFFF_FFFF;
      req[2] = 49'h0_0000_0002_0000;
      req[3] = 49'h0_0000_0000_0001;
      got_q.delete();
      err_cnt = 0;
      send_frame(784, 1'b0);
      idle(3);
      checks++;
      if (got_q.size() !== 1) begin
        fails++;
        $display("FAIL pat%0d_count got=%0d required 1", k, got_q.size());
      end
      checks++;
      if (first_got() !== req[k] || first_got() !== model()) begin
        fails++;
        $display("FAIL pat%0d_bits got=%h required %h", k, first_got(), req[k]);
      end
      checks++;
      if (err_cnt !== 0) begin
        fails++;
        $display("FAIL pat%0d_err got=%0d required 0", k, err_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [48:0] exp_v;
    for (int k = 0; k < 4; k++) begin
      fill(0, 127);
      exp_v = model();
      got_q.delete();
      send_frame(784, 1'b1);
      idle(3);
      checks++;
      if (got_q.size() !== 1 || first_got() !== exp_v) begin
        fails++;
        $display("FAIL rand%0d_bits got=%h n=%0d required %h n=1",
                 k, first_got(), got_q.size(), exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [48:0] exp1, exp2;
    bit held_bad;
    held_bad = 1'b0;
    got_q.delete();
    out_ready = 1'b0;
    fill(0, 127);
    exp1 = model();
    send_frame(784, 1'b0);
    fill(0, 127);
    exp2 = model();
    for (int i = 0; i < 783; i++) begin
      send(img[i], i == 0);
      if (out_valid !== 1'b1 || out_bits !== exp1) held_bad = 1'b1;
    end
    checks++;
    if (held_bad) begin
      fails++;
      $display("FAIL bp_held got=%h required %h", out_bits, exp1);
    end
    pix_valid = 1'b1;
    pix_data  = img[783][7:0];
    pix_sof   = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall got=%b required 0", pix_ready);
    end
    idle(3);
    #1;
    checks++;
    if (pix_ready !== 1'b0 || out_bits !== exp1) begin
      fails++;
      $display("FAIL bp_stall_hold ready=%b bits=%h required 0 %h",
               pix_ready, out_bits, exp1);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got=%b required 1", pix_ready);
    end
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== exp2) begin
      fails++;
      $display("FAIL bp_next valid=%b bits=%h required 1 %h",
               out_valid, out_bits, exp2);
    end
    idle(3);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== exp1 || got_q[1] !== exp2) begin
      fails++;
      $display("FAIL bp_seq n=%0d first=%h required n=2 %h %h",
               got_q.size(), first_got(), exp1, exp2);
    end
  endtask

  task automatic test_sof_restart();
    logic [48:0] exp_v;
    got_q.delete();
    err_cnt = 0;
    fill(0, 255);
    send_frame(300, 1'b0);
    fill(0, 127);
    exp_v = model();
    send_frame(784, 1'b0);
    idle(3);
    checks++;
    if (err_cnt !== 1) begin
      fails++;
      $display("FAIL sof_err got=%0d required 1", err_cnt);
    end
    checks++;
    if (got_q.size() !== 1 || first_got() !== exp_v) begin
      fails++;
      $display("FAIL sof_bits got=%h n=%0d required %h n=1",
               first_got(), got_q.size(), exp_v);
    end
  endtask

  task automatic test_reset_mid();
    logic [48:0] exp_v;
    got_q.delete();
    fill(0, 255);
    send_frame(500, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_valid got=%b required 0", out_valid);
    end
    for (int i = 0; i < 300; i++) send(img[i], 1'b0);
    idle(3);
    checks++;
    if (got_q.size() !== 0) begin
      fails++;
      $display("FAIL rstmid_drop got=%0d required 0", got_q.size());
    end
    fill(0, 127);
    exp_v = model();
    send_frame(784, 1'b0);
    idle(3);
    checks++;
    if (got_q.size() !== 1 || first_got() !== exp_v) begin
      fails++;
      $display("FAIL rstmid_bits got=%h n=%0d required %h n=1",
               first_got(), got_q.size(), exp_v);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_patterns();
    test_random();
    test_back_to_back();
    test_sof_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/mnist_pool_binarizer.md
Name: mnist_pool_binarizer

Overview:
Front-end stage for the MNIST gate-network classifiers. It accepts a raster-order 28x28 8-bit greyscale pixel stream and sums each non-overlapping 4x4 block. Each block sum is thresholded to one bit. The resulting 49-bit feature vector is presented with a valid/ready handshake, in exactly the 49-bit `in_bits` format that the 2-class tiny gate network consumes.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 28, image width and height in pixels (square).
- POOL, 4, pooling block edge in pixels; IMG_W % POOL == 0.
- BLOCK_THRESH, 1024, block-sum threshold; a feature bit is 1 when sum >= BLOCK_THRESH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- pix_data  in  PIX_W  unsigned pixel value.
- pix_sof  in  1  marks pixel (0,0) of a frame.
- out_valid  out  1  feature vector valid.
- out_ready  in  1  downstream accepts the vector.
- out_bits  out  GRID*GRID (49)  feature vector; bit index = block_row*GRID + block_col, where GRID = IMG_W/POOL.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; row/col counters 0; accumulators and working vector 0; out_valid=0; out_bits=0; frame_err=0. Reset mid-frame discards the partial frame and any unconsumed output.
- Accumulator width: ACC_W = PIX_W + 2*clog2(POOL) = 12. Addition is unsigned and never saturates (max sum 4080).
- FSM:
  - IDLE: pix_ready=1. Accepted pixels without pix_sof are dropped. A pixel with pix_sof is processed as pixel (0,0), then the FSM goes to ACCUM.
  - ACCUM: every accepted pixel at (r,c) updates acc[c/POOL].
    - First pixel of a block (r%POOL==0 and c%POOL==0): acc is loaded with pix_data, not added.
    - Last pixel of a block (r%POOL==POOL-1 and c%POOL==POOL-1): work[(r/POOL)*GRID + c/POOL] <= (acc + pix_data >= BLOCK_THRESH).
    - The column counter wraps at IMG_W-1 and increments the row counter.
    - On the last frame pixel (r=c=IMG_W-1, pixel 783): out_bits <= work with the final bit merged; out_valid <= 1; FSM returns to IDLE.
- Latency: out_valid rises on the clock edge that accepts pixel 783, so it is visible the following cycle.
- Output handshake: out_bits is held stable while out_valid=1. out_valid clears on out_valid & out_ready unless a new vector is published in the same cycle, in which case it stays 1 with the new bits.
- Backpressure:
  - pix_ready = 0 only when in ACCUM at pixel 783 and out_valid=1 and out_ready=0 (combinational path from out_ready).
  - All other pixels, including those of the next frame, are accepted while an output is pending.
  - Accepting pixel 783 in the same cycle that the old vector is taken is legal; the new vector replaces it without a bubble.
- pix_sof asserted in ACCUM:
  - The partial frame is discarded and frame_err pulses for one cycle.
  - The pixel is treated as (0,0) of a new frame; the FSM stays in ACCUM.
  - A pending out_bits/out_valid is unaffected.
- A pix_valid=0 cycle has no effect on any counter or accumulator.
- Stalled pixel 783: pix_data and pix_sof must be held by the source per the valid/ready rules. If pix_sof is asserted on the stalled pixel, the mid-frame sof rule applies when it is accepted.

Decomposition:
- Shared package mnist_pkg holds:
  - constants MNIST_PIX_W=8, MNIST_IMG_W=28, MNIST_POOL=4, MNIST_GRID=7, MNIST_N_FEAT=49, MNIST_ACC_W=12;
  - typedef feat_vec_t (logic [48:0]), shared with the gate-network wrappers;
  - typedef acc_t.
- One sub-module: mnist_block_acc, a bank of GRID accumulators with load/add/threshold per column slot. The top level keeps the FSM, counters, working vector and output register.

Test Plan:
- All-zero frame with out_ready=1 -> a single out_valid pulse, out_bits=49'h0, frame_err=0.
- All-255 frame -> out_bits=49'h1_FFFF_FFFF_FFFF.
- Block (row 2, col 3) all 255, rest 0 -> only bit 17 set (49'h0_0000_0002_0000).
- Threshold boundary, BLOCK_THRESH=1024: block 0 all 64 (sum 1024) -> bit0=1; block 1 all 63 (sum 1008) -> bit1=0; block 2 = fifteen 64s + one 63 (sum 1023) -> bit2=0.
- Backpressure:
  - out_ready=0 while streaming two frames back-to-back -> frame 1 bits held stable and pix_ready=0 at frame 2 pixel 783 only.
  - Raising out_ready -> frame 1 consumed, pixel 783 accepted the same cycle, and frame 2 bits appear next cycle with out_valid still 1.
- Framing and reset:
  - pix_sof at pixel 300 of frame A, then 784 good pixels -> frame_err pulses once; exactly one vector is output, computed from the restarted frame.
  - rst_n=0 at pixel 500 -> out_valid=0 and no vector output until a new pix_sof frame completes.
